// File: rtl/systolic_act_skew_feeder_if.sv
// Load-path handshake carrying activation vectors from the producer into the skew feeder.
interface systolic_act_skew_feeder_if #(
   parameter int N     = 4,
   parameter int WIDTH = 16
);
   logic               in_valid;
   logic               in_ready;
   logic [N*WIDTH-1:0] in_vec;
   logic               in_last;

   modport master (output in_valid, in_vec, in_last, input in_ready);
   modport slave  (input in_valid, in_vec, in_last, output in_ready);
endinterface

// File: rtl/systolic_act_skew_feeder.sv
// Activation FIFO plus diagonal skew for the top PE row; inserts N drain bubbles per batch
// and pulses batch_done once the last lane has been driven.
module systolic_act_skew_feeder #(
   parameter int N     = 4,
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   systolic_act_skew_feeder_if.slave    load,
   input  logic                         feed_en,
   output logic [N*WIDTH-1:0]           act_out,
   output logic [N-1:0]                 en_out,
   output logic                         busy,
   output logic                         batch_done,
   output logic [31:0]                  vec_count,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);
   localparam int LW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(N+1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

   state_t             state;
   logic [N*WIDTH:0]   mem [DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      drain_cnt;
   logic [N*WIDTH:0]   head;
   logic               full, push, pop;

   assign full          = fifo_level == LW'(DEPTH);
   assign load.in_ready = !rst && !full;
   assign push          = load.in_valid && load.in_ready;
   assign pop           = (state != DRAIN) && feed_en && (fifo_level != '0);
   assign head          = mem[rd_ptr];
   assign busy          = state != IDLE;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {load.in_last, load.in_vec};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Drain counter ends at 1 so batch_done lands the cycle after lane N-1's final output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         vec_count  <= '0;
         drain_cnt  <= '0;
         batch_done <= 1'b0;
      end else begin
         batch_done <= 1'b0;
         case (state)
            IDLE: if (pop) begin
               vec_count <= 32'd1;
               drain_cnt <= CW'(N);
               state     <= head[N*WIDTH] ? DRAIN : FEED;
            end
            FEED: if (pop) begin
               if (vec_count != '1) vec_count <= vec_count + 32'd1;
               if (head[N*WIDTH]) begin
                  drain_cnt <= CW'(N);
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               if (drain_cnt == CW'(1)) begin
                  batch_done <= 1'b1;
                  drain_cnt  <= '0;
                  state      <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [WIDTH-1:0] dq [i+1];
      logic [i:0]       eq;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= i; k++) dq[k] <= '0;
            eq <= '0;
         end else begin
            dq[0] <= pop ? head[i*WIDTH +: WIDTH] : '0;
            eq[0] <= pop;
            for (int k = 1; k <= i; k++) begin
               dq[k] <= dq[k-1];
               eq[k] <= eq[k-1];
            end
         end
      end

      assign act_out[i*WIDTH +: WIDTH] = dq[i];
      assign en_out[i]                 = eq[i];
   end
endmodule

// File: tb/tb_systolic_act_skew_feeder.sv
// Bench for systolic_act_skew_feeder: directed scenarios plus random traffic against a
// cycle-scheduled model (a pop at t lands lane i at t+1+i, done at t_last+N+1).
module tb_systolic_act_skew_feeder;
   localparam int N     = 4;
   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH+1);
   localparam int OW    = N*WIDTH + N + 2 + 32 + LW + 1;

   typedef logic [N*WIDTH-1:0] vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              feed_en = 1'b0;
   vec_t              act_out;
   logic [N-1:0]      en_out;
   logic              busy, batch_done;
   logic [31:0]       vec_count;
   logic [LW-1:0]     fifo_level;

   systolic_act_skew_feeder_if #(.N(N), .WIDTH(WIDTH)) bus ();

   systolic_act_skew_feeder #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (bus),
      .feed_en    (feed_en),
      .act_out    (act_out),
      .en_out     (en_out),
      .busy       (busy),
      .batch_done (batch_done),
      .vec_count  (vec_count),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: FIFO contents plus per-cycle scheduled outputs.
   int                cyc = 0;
   logic [N*WIDTH:0]  mq [$];
   vec_t              sch_act [int];
   logic [N-1:0]      sch_en [int];
   bit                sch_done [int];
   int                busy_start, busy_end, no_pop_until, last_pop = -100;
   logic [31:0]       vc_m;

   vec_t          e_act;
   logic [N-1:0]  e_en;
   logic          e_done, e_busy, e_rdy;
   logic [31:0]   e_vc;
   logic [LW-1:0] e_lvl;

   function automatic vec_t ramp(int base);
      vec_t v;
      for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(base + i);
      return v;
   endfunction

   function automatic vec_t splat(int x);
      vec_t v;
      for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'(x);
      return v;
   endfunction

   function automatic logic [OW-1:0] obs();
      return {act_out, en_out, batch_done, busy, vec_count, fifo_level, bus.in_ready};
   endfunction

   function automatic logic [OW-1:0] expv();
      return {e_act, e_en, e_done, e_busy, e_vc, e_lvl, e_rdy};
   endfunction

   function automatic string diag();
      return $sformatf("act %h want %h en %b want %b done %b want %b busy %b want %b vc %0d want %0d lvl %0d want %0d rdy %b want %b",
         act_out, e_act, en_out, e_en, batch_done, e_done, busy, e_busy, vec_count, e_vc,
         fifo_level, e_lvl, bus.in_ready, e_rdy);
   endfunction

   task automatic model_reset();
      mq.delete();
      sch_act.delete();
      sch_en.delete();
      sch_done.delete();
      vc_m         = '0;
      busy_start   = 0;
      busy_end     = -1;
      no_pop_until = -1;
   endtask

   task automatic sample();
      @(negedge clk);
      e_act  = sch_act.exists(cyc) ? sch_act[cyc] : '0;
      e_en   = sch_en.exists(cyc) ? sch_en[cyc] : '0;
      e_done = sch_done.exists(cyc);
      e_busy = (cyc >= busy_start) && (cyc <= busy_end);
      e_vc   = vc_m;
      e_lvl  = LW'(mq.size());
      e_rdy  = mq.size() < DEPTH;
   endtask

   task automatic advance();
      logic [N*WIDTH:0] ent;
      vec_t             a;
      logic [N-1:0]     e;
      bit               can_pop, can_push;
      can_pop  = feed_en && (mq.size() > 0) && (cyc > no_pop_until);
      can_push = bus.in_valid && (mq.size() < DEPTH);
      if (can_pop) begin
         ent      = mq.pop_front();
         last_pop = cyc;
         if (cyc >= busy_start && cyc <= busy_end) begin
            if (vc_m != 32'hFFFF_FFFF) vc_m++;
         end else begin
            vc_m       = 32'd1;
            busy_start = cyc + 1;
            busy_end   = 32'h7FFF_FFFF;
         end
         for (int i = 0; i < N; i++) begin
            a = sch_act.exists(cyc+1+i) ? sch_act[cyc+1+i] : '0;
            e = sch_en.exists(cyc+1+i) ? sch_en[cyc+1+i] : '0;
            a[i*WIDTH +: WIDTH] = ent[i*WIDTH +: WIDTH];
            e[i] = 1'b1;
            sch_act[cyc+1+i] = a;
            sch_en[cyc+1+i]  = e;
         end
         if (ent[N*WIDTH]) begin
            busy_end           = cyc + N;
            no_pop_until       = cyc + N;
            sch_done[cyc+N+1]  = 1'b1;
         end
      end
      if (can_push) mq.push_back({bus.in_last, bus.in_vec});
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic release_rst();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      feed_en      = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1;
      bus.in_vec   = ramp(1);
      bus.in_last  = 1'b0;
      rst          = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== {OW{1'b0}}) begin
         errors++;
         $display("FAIL reset_hold: outputs %h want all zero", obs());
      end
      model_reset();
      release_rst();
      sample();
      checks++;
      if (bus.in_ready !== 1'b1 || fifo_level !== '0) begin
         errors++;
         $display("FAIL reset_release: rdy %b want 1 lvl %0d want 0", bus.in_ready, fifo_level);
      end
      // Leave one vector parked in the FIFO, then reset with in_valid still high.
      bus.in_valid = 1'b1;
      advance();
      sample();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL reset_park c%0d %s", cyc, diag()); end
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== {OW{1'b0}}) begin
         errors++;
         $display("FAIL reset_idle: outputs %h want all zero", obs());
      end
      model_reset();
      release_rst();
      sample();
      checks++;
      if (obs() !== expv() || fifo_level !== '0) begin errors++; $display("FAIL reset_idle_release %s", diag()); end
      advance();
   endtask

   task automatic test_single();
      int t0 = cyc;
      int j;
      bus.in_valid = 1'b1;
      bus.in_vec   = ramp(1);
      bus.in_last  = 1'b1;
      feed_en      = 1'b1;
      for (int k = 0; k < 9; k++) begin
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL single c%0d %s", cyc, diag()); end
         if (last_pop >= t0 && cyc > last_pop && cyc <= last_pop + N) begin
            j = cyc - last_pop - 1;
            checks++;
            if (act_out[j*WIDTH +: WIDTH] !== WIDTH'(j + 1) || en_out !== N'(1 << j)) begin
               errors++;
               $display("FAIL single_lane%0d: act %0d en %b want %0d en %b", j,
                        act_out[j*WIDTH +: WIDTH], en_out, j + 1, N'(1 << j));
            end
         end
         if (last_pop >= t0 && cyc == last_pop + N + 1) begin
            checks++;
            if (batch_done !== 1'b1 || vec_count !== 32'd1) begin
               errors++;
               $display("FAIL single_done: done %b vc %0d want 1 1", batch_done, vec_count);
            end
         end
         advance();
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic test_back_to_back();
      int en3 = 0, dones = 0;
      int l0 [$];
      int l3 [$];
      feed_en = 1'b1;
      for (int k = 0; k < 12; k++) begin
         bus.in_valid = k < 3;
         bus.in_vec   = ramp(1 + 4*k);
         bus.in_last  = k == 2;
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL b2b c%0d %s", cyc, diag()); end
         if (en_out[0]) l0.push_back(int'(act_out[0 +: WIDTH]));
         if (en_out[3]) begin en3++; l3.push_back(int'(act_out[3*WIDTH +: WIDTH])); end
         if (batch_done) dones++;
         advance();
      end
      checks++;
      if (l0.size() != 3 || l0[0] != 1 || l0[1] != 5 || l0[2] != 9) begin
         errors++;
         $display("FAIL b2b_lane0: got %p want 1 5 9", l0);
      end
      checks++;
      if (l3.size() != 3 || l3[0] != 4 || l3[1] != 8 || l3[2] != 12) begin
         errors++;
         $display("FAIL b2b_lane3: got %p want 4 8 12", l3);
      end
      checks++;
      if (en3 != 3 || dones != 1 || vec_count !== 32'd3) begin
         errors++;
         $display("FAIL b2b_counts: en3 %0d done %0d vc %0d want 3 1 3", en3, dones, vec_count);
      end
   endtask

   task automatic test_full();
      int n0 = 0, first = -1, last = -1;
      feed_en = 1'b0;
      for (int k = 0; k < 9; k++) begin
         bus.in_valid = 1'b1;
         bus.in_vec   = ramp(16*k);
         bus.in_last  = k == 7;
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL full_fill c%0d %s", cyc, diag()); end
         advance();
      end
      bus.in_valid = 1'b0;
      sample();
      checks++;
      if (fifo_level !== LW'(8) || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_level: lvl %0d rdy %b want 8 0", fifo_level, bus.in_ready);
      end
      feed_en = 1'b1;
      advance();
      for (int k = 0; k < 16; k++) begin
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL full_drain c%0d %s", cyc, diag()); end
         if (en_out[0]) begin
            n0++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         advance();
      end
      checks++;
      if (n0 != 8 || last - first != 7) begin
         errors++;
         $display("FAIL full_stream: en0 cycles %0d span %0d want 8 7", n0, last - first);
      end
   endtask

   task automatic test_bubbles();
      int t0 = cyc;
      int done_at = -1;
      logic [WIDTH:0] cap [$];
      feed_en = 1'b1;
      for (int k = 0; k < 14; k++) begin
         bus.in_valid = (k == 0) || (k == 3);
         bus.in_vec   = (k == 0) ? splat(7) : splat(-1);
         bus.in_last  = k == 3;
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL bubbles c%0d %s", cyc, diag()); end
         if ((cap.size() > 0 || en_out[3]) && cap.size() < 4)
            cap.push_back({en_out[3], act_out[3*WIDTH +: WIDTH]});
         if (batch_done) done_at = cyc;
         advance();
      end
      checks++;
      if (cap.size() != 4 || cap[0] !== {1'b1, 16'h0007} || cap[1] !== 17'h0 ||
          cap[2] !== 17'h0 || cap[3] !== {1'b1, 16'hFFFF}) begin
         errors++;
         $display("FAIL bubbles_lane3: got %p want 7/1 0/0 0/0 ffff/1", cap);
      end
      checks++;
      if (done_at != t0 + 4 + N + 1) begin
         errors++;
         $display("FAIL bubbles_done: at %0d want %0d", done_at, t0 + 4 + N + 1);
      end
   endtask

   task automatic test_reset_drain();
      int dones = 0;
      feed_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.in_vec   = ramp(1 + 4*k);
         bus.in_last  = k == 0;
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL rdrain_setup c%0d %s", cyc, diag()); end
         advance();
      end
      bus.in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || fifo_level !== LW'(2)) begin
         errors++;
         $display("FAIL rdrain_pre: busy %b lvl %0d want 1 2", busy, fifo_level);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (obs() !== {OW{1'b0}}) begin
         errors++;
         $display("FAIL rdrain_zero: outputs %h want all zero", obs());
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++;
         if (batch_done !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL rdrain_hold: done %b lvl %0d want 0 0", batch_done, fifo_level);
         end
      end
      model_reset();
      release_rst();
      feed_en = 1'b1;
      for (int k = 0; k < 9; k++) begin
         bus.in_valid = k == 0;
         bus.in_vec   = ramp(20);
         bus.in_last  = 1'b1;
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL rdrain_after c%0d %s", cyc, diag()); end
         if (batch_done) dones++;
         advance();
      end
      checks++;
      if (dones != 1) begin
         errors++;
         $display("FAIL rdrain_batch: done pulses %0d want 1", dones);
      end
   endtask

   task automatic test_random();
      vec_t v;
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         bus.in_vec   = v;
         bus.in_valid = $urandom_range(0, 2) != 0;
         bus.in_last  = $urandom_range(0, 5) == 0;
         feed_en      = $urandom_range(0, 3) != 0;
         sample();
         checks++;
         if (obs() !== expv()) begin errors++; $display("FAIL random c%0d %s", cyc, diag()); end
         advance();
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_vec   = '0;
      bus.in_last  = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_bubbles();
      test_reset_drain();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/systolic_act_skew_feeder.md
Name: systolic_act_skew_feeder

Overview:
- Upstream feeder for the weight-stationary PE grid. Buffers activation vectors from the load path and drives the top PE row.
- Applies the diagonal skew: lane i is delayed i cycles relative to lane 0. The per-lane enable travels with the data.
- Inserts drain bubbles after the last vector of a batch, then signals batch completion to the controller.

Parameters:
- N, 4, array columns (lanes); N >= 1.
- WIDTH, 16, signed activation width; matches the PE WIDTH.
- DEPTH, 8, FIFO depth in vectors; power of two, >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  producer has a vector
- in_ready  output  1  FIFO can accept; equals !full
- in_vec  input  N*WIDTH  lane i at [i*WIDTH +: WIDTH], signed
- in_last  input  1  marks the final vector of a batch
- feed_en  input  1  permits pops; 0 inserts bubbles
- act_out  output  N*WIDTH  lane i drives column i in_up of the top PE row
- en_out  output  N  en_out[i] drives the enable of column i
- busy  output  1  state != IDLE
- batch_done  output  1  one-cycle pulse
- vec_count  output  32  vectors popped in the current batch
- fifo_level  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async): FIFO emptied, all skew registers 0, act_out=0, en_out=0, busy=0, batch_done=0, vec_count=0, fifo_level=0, state IDLE. in_ready=1 while rst is low.
- Push: occurs when in_valid && in_ready. Stores {in_last, in_vec}.
- in_ready is derived from the current occupancy only. A same-cycle pop never enables a push when full.
- No empty bypass: a pop requires fifo_level>0 at the start of the cycle.
- Simultaneous push and pop: level unchanged.
- Pop condition: state is IDLE or FEED, feed_en=1, and FIFO not empty.
- Skew timing: a vector popped in cycle t appears with lane i on act_out[i] and en_out[i]=1 in cycle t+1+i.
- Non-pop cycles inject a bubble at stage 0: data 0, enable 0.
- Lanes carry only registered values. act_out and en_out are never combinational from the FIFO.
- State machine:
  - IDLE: on a pop, clear vec_count then set it to 1. Go to DRAIN if the popped entry has last, otherwise FEED.
  - FEED: each pop increments vec_count. A pop with last goes to DRAIN. Otherwise stay in FEED, with bubbles while the FIFO is empty or feed_en=0.
  - DRAIN: no pops regardless of FIFO or feed_en. Load counter = N at entry and decrement each cycle. When it hits 0, pulse batch_done and go to IDLE.
- batch_done timing: last vector popped at cycle t_L -> batch_done=1 exactly in cycle t_L+N+1, the cycle after the final lane output.
- busy falls in the cycle batch_done pulses.
- Pushes are accepted in every state. Vectors for the next batch may queue during DRAIN.
- Back-to-back batches: the IDLE pop may occur in the cycle after batch_done.
- vec_count wrap: saturates at 2^32-1.
- Data is passed unmodified. No arithmetic on activations.
- Reset mid-operation (any state): immediate return to the reset values. In-flight and queued data are discarded.

Test Plan:
1. Assert rst mid-idle with in_valid=1 -> all outputs 0, in_ready=0 during rst. After release, in_ready=1 and fifo_level=0.
2. N=4, push {1,2,3,4} with in_last=1, feed_en=1, popped at cycle t:
   - act_out lane0=1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4.
   - en_out is one-hot stepping 0001->1000 over those cycles.
   - batch_done at t+5; vec_count=1.
3. Three back-to-back vectors {1..4},{5..8},{9..12}, last on the third:
   - lane0 shows 1,5,9 on consecutive cycles; lane3 shows 4,8,12 three cycles later.
   - en_out[3] is high for 3 cycles; vec_count=3; single batch_done pulse.
4. feed_en=0, push 9 vectors -> in_ready falls after the 8th, fifo_level=8, 9th not accepted. Raise feed_en -> 8 consecutive pops, en_out[0] high 8 cycles, no gaps.
5. Push v0={7,7,7,7}, idle 2 cycles, push v1={-1,-1,-1,-1} with last -> each lane shows 7, then two bubble cycles (act 0, en 0), then -1 (0xFFFF); batch_done N+1 cycles after the v1 pop.
6. Assert rst in DRAIN with 2 vectors queued -> outputs zeroed, fifo_level=0, no batch_done; the next batch runs normally.
